// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared state encoding and sizing constants for the RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int ADDR_W   = 2;
    localparam int MAX_NREQ = 4;
    localparam int PTR_W    = $clog2(MAX_NREQ);

endpackage

`default_nettype wire

// File: rtl/ram_access_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; first pending request at or
//               after the priority pointer wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] idx
);

    logic w_found;

    // Outer loop walks offsets from the pointer so the nearest request wins.
    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        for (int ofs = 0; ofs < NREQ; ofs++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!w_found && req[k] &&
                    ((int'(ptr) + ofs == k) || (int'(ptr) + ofs == k + NREQ))) begin
                    grant[k] = 1'b1;
                    idx      = PTR_W'(k);
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_access_arbiter.sv
// ============================================================================
// Module      : ram_access_arbiter
// Description : Round-robin arbiter sequencing setup/enable/complete accesses
//               to the 4-byte RAM decoder on behalf of NREQ requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DW      = 8,
    parameter int ACC_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [2*NREQ-1:0]    addr,
    input  logic [DW*NREQ-1:0]   wdata,
    output logic [NREQ-1:0]      ack,
    output logic [DW-1:0]        rdata,
    output logic                 busy,
    output logic                 ram_s0,
    output logic                 ram_s1,
    output logic                 ram_en_n,
    output logic                 ram_we_n,
    output logic [DW-1:0]        ram_wdata,
    input  logic [DW-1:0]        ram_rdata
);

    localparam logic [3:0] c_acc_init = 4'(ACC_CYC - 1);

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_idx;
    logic               r_we;
    logic [3:0]         r_cnt;

    logic [NREQ-1:0]    w_grant;
    logic [PTR_W-1:0]   w_idx;
    logic               w_we_sel;
    logic [ADDR_W-1:0]  w_addr_sel;
    logic [DW-1:0]      w_wdata_sel;
    logic [NREQ-1:0]    w_ack_set;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req   (req),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx)
    );

    // One-hot grant steers the winner's inputs without variable-width indexing.
    always_comb begin
        w_we_sel    = 1'b0;
        w_addr_sel  = '0;
        w_wdata_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_we_sel    = w_we_sel | we[i];
                w_addr_sel  = w_addr_sel | addr[i*ADDR_W +: ADDR_W];
                w_wdata_sel = w_wdata_sel | wdata[i*DW +: DW];
            end
        end
    end

    assign w_ack_set = NREQ'(1) << r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_we      <= 1'b0;
            r_cnt     <= '0;
            ack       <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            ram_s0    <= 1'b0;
            ram_s1    <= 1'b0;
            ram_en_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            ram_wdata <= '0;
        end else begin
            ack <= '0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_idx     <= w_idx;
                        r_we      <= w_we_sel;
                        ram_s1    <= w_addr_sel[1];
                        ram_s0    <= w_addr_sel[0];
                        ram_wdata <= w_wdata_sel;
                        busy      <= 1'b1;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    ram_en_n <= 1'b0;
                    ram_we_n <= ~r_we;
                    r_cnt    <= c_acc_init;
                    r_state  <= ACCESS;
                end
                ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        ram_en_n <= 1'b1;
                        ram_we_n <= 1'b1;
                        ack      <= w_ack_set;
                        if (!r_we) begin
                            rdata <= ram_rdata;
                        end
                        r_state  <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    // Just-served requester drops to lowest priority.
                    if (r_idx == PTR_W'(NREQ - 1)) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= r_idx + PTR_W'(1);
                    end
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
